booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 155 +++++++++++++++
 tb/tb_booth_mult_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq -- sequential signed Booth multiplier (Y = A * B).
//
// The default build uses radix-2 recoding: N iterations, one shift per iteration.
// Define BOOTH_RADIX4_EN to build radix-4 recoding instead: N/2 iterations, two
// shifts per iteration.
//
// Ports
//   clk       : clock; all state updates on its rising edge
//   rst       : asynchronous reset, active low
//   in_valid  : A/B valid (sampled only in IDLE)
//   in_ready  : high in IDLE
//   A, B      : N-bit signed multiplicand / multiplier
//   abort     : synchronous cancel; returns to IDLE and leaves Y untouched
//   out_valid : high in DONE; Y holds a finished product
//   out_ready : consumer accepts Y
//   Y         : 2N-bit signed product; holds the last completed product
//   busy      : high in RUN
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one Booth iteration per edge
// DONE  | product on Y, waiting for out_ready

module booth_mult_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Y,
  output logic           busy
);

`ifdef BOOTH_RADIX4_EN
  localparam int ITER = N / 2;
  // Two guard bits so that adding -2M with M = -2^(N-1) cannot overflow.
  localparam int AW   = N + 2;
`else
  localparam int ITER = N;
  localparam int AW   = N + 1;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N-1:0]   m;
  logic [N-1:0]   lq;
  logic [AW-1:0]  acc;
  logic           q_1;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] y_q;

  logic [AW-1:0]  m_ext;
  logic [AW-1:0]  op;
  logic           sub;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  acc_nxt;
  logic [N-1:0]   lq_nxt;
  logic           q_1_nxt;

  assign m_ext = {{(AW-N){m[N-1]}}, m};

  always_comb begin
    op  = '0;
    sub = 1'b0;
`ifdef BOOTH_RADIX4_EN
    unique case ({lq[1:0], q_1})
      3'b001, 3'b010: op = m_ext;
      3'b011:         op = {m_ext[AW-2:0], 1'b0};
      3'b100: begin
        op  = {m_ext[AW-2:0], 1'b0};
        sub = 1'b1;
      end
      3'b101, 3'b110: begin
        op  = m_ext;
        sub = 1'b1;
      end
      default:        op = '0;
    endcase
    sum     = sub ? (acc - op) : (acc + op);
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    lq_nxt  = {sum[1:0], lq[N-1:2]};
    q_1_nxt = lq[1];
`else
    unique case ({lq[0], q_1})
      2'b01:   op = m_ext;
      2'b10: begin
        op  = m_ext;
        sub = 1'b1;
      end
      default: op = '0;
    endcase
    sum     = sub ? (acc - op) : (acc + op);
    acc_nxt = {sum[AW-1], sum[AW-1:1]};
    lq_nxt  = {sum[0], lq[N-1:1]};
    q_1_nxt = lq[0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      m     <= '0;
      lq    <= '0;
      acc   <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      y_q   <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= A;
            lq    <= B;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          lq  <= lq_nxt;
          q_1 <= q_1_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // The exact product fits in the low 2N bits of {acc, lq}.
            y_q   <= {acc_nxt[N-1:0], lq_nxt};
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign Y         = y_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
  localparam int N = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = N / 2;
`else
  localparam int ITER = N;
`endif
  localparam int N_OPS = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] Y;
  logic           busy;

  int errors = 0;
  int checks = 0;
  logic [2*N-1:0] last_y;

  booth_mult_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .Y(Y), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (2*N)'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Runs until out_valid, scrambling the ignored inputs meanwhile; lat=-1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      A = N'($urandom);
      B = N'($urandom);
      tick();
      lat++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (Y !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: Y=%h ov=%b busy=%b ir=%b, want Y=0 ov=0 busy=0 ir=1",
               Y, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    last_y = '0;
  endtask

  task automatic test_basic();
    int lat;
    accept(8'd3, 8'd5);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: busy=%b ir=%b, want busy=1 ir=0", busy, in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat !== ITER) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want %0d", lat, ITER);
    end
    checks++;
    if (Y !== 16'h000F) begin
      errors++;
      $display("FAIL basic_y: got %h, want 000f", Y);
    end
    last_y = 16'h000F;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    logic [N-1:0]   ta [3];
    logic [N-1:0]   tb [3];
    logic [2*N-1:0] ty [3];
    int lat;
    ta = '{8'h80, 8'h80, 8'h00};
    tb = '{8'h80, 8'h7F, 8'hFF};
    ty = '{16'h4000, 16'hC080, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      accept(ta[i], tb[i]);
      wait_done(lat);
      checks++;
      if (lat !== ITER || Y !== ty[i]) begin
        errors++;
        $display("FAIL corner%0d: Y=%h lat=%0d, want Y=%h lat=%0d", i, Y, lat, ty[i], ITER);
      end
      last_y = ty[i];
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept(8'hF9, 8'd6);
    wait_done(lat);
    checks++;
    if (lat !== ITER) begin
      errors++;
      $display("FAIL bp_latency: got %0d, want %0d", lat, ITER);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Y !== 16'hFFD6 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: Y=%h ir=%b ov=%b, want Y=ffd6 ir=0 ov=1",
                 i, Y, in_ready, out_valid);
      end
      tick();
    end
    last_y = 16'hFFD6;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Y !== 16'hFFD6) begin
      errors++;
      $display("FAIL bp_release: ir=%b ov=%b Y=%h, want ir=1 ov=0 Y=ffd6", in_ready, out_valid, Y);
    end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    accept(8'd5, 8'd9);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || Y !== last_y) begin
      errors++;
      $display("FAIL abort_idle: ir=%b busy=%b Y=%h, want ir=1 busy=0 Y=%h",
               in_ready, busy, Y, last_y);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_valid: out_valid seen=1, want 0");
    end
    accept(8'd2, 8'd2);
    wait_done(lat);
    checks++;
    if (lat !== ITER || Y !== 16'h0004) begin
      errors++;
      $display("FAIL abort_next: Y=%h lat=%0d, want Y=0004 lat=%0d", Y, lat, ITER);
    end
    last_y = 16'h0004;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    accept(8'd100, 8'hC3);
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (Y !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: Y=%h ir=%b busy=%b, want Y=0 ir=1 busy=0", Y, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    last_y = '0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen || Y !== '0) begin
      errors++;
      $display("FAIL rst_no_valid: seen=%b Y=%h, want seen=0 Y=0", seen, Y);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp_y;
    int lat;
    int n_results = 0;
    int n_wait;
    for (int op = 0; op < N_OPS; op++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      a = N'($urandom);
      b = N'($urandom);
      exp_y = model(a, b);
      accept(a, b);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL rand_accept op%0d: busy=%b, want 1", op, busy);
      end
      wait_done(lat);
      if (lat > 0) n_results++;
      checks++;
      if (lat !== ITER || Y !== exp_y) begin
        errors++;
        $display("FAIL rand op%0d a=%h b=%h: Y=%h lat=%0d, want Y=%h lat=%0d",
                 op, a, b, Y, lat, exp_y, ITER);
      end
      n_wait = $urandom_range(0, 3);
      for (int w = 0; w < n_wait; w++) begin
        tick();
        checks++;
        if (Y !== exp_y || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL rand_hold op%0d: Y=%h ov=%b, want Y=%h ov=1", op, Y, out_valid, exp_y);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checks++;
    if (n_results !== N_OPS) begin
      errors++;
      $display("FAIL rand_count: got %0d results, want %0d", n_results, N_OPS);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    last_y = '0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
